// File: rtl/axis_measure_mc.sv
// Inline multi-channel AXI-Stream measurer: zero-latency passthrough plus per-channel
// beat/packet/stall counters and last-beat capture, read out over AXI-Lite. Stall counters
// are built only when AXIS_MEASURE_STALL_EN is defined.
module axis_measure_mc #(
  parameter int unsigned NUM_CH        = 1,
  parameter int unsigned DATA_BYTES    = 64,
  parameter int unsigned CNT_WIDTH     = 64,
  parameter bit          START_ENABLED = 1'b0
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic                             s_axi_control_awvalid,
  output logic                             s_axi_control_awready,
  input  logic [15:0]                      s_axi_control_awaddr,
  input  logic                             s_axi_control_wvalid,
  output logic                             s_axi_control_wready,
  input  logic [31:0]                      s_axi_control_wdata,
  input  logic [3:0]                       s_axi_control_wstrb,
  output logic                             s_axi_control_bvalid,
  input  logic                             s_axi_control_bready,
  output logic [1:0]                       s_axi_control_bresp,
  input  logic                             s_axi_control_arvalid,
  output logic                             s_axi_control_arready,
  input  logic [15:0]                      s_axi_control_araddr,
  output logic                             s_axi_control_rvalid,
  input  logic                             s_axi_control_rready,
  output logic [31:0]                      s_axi_control_rdata,
  output logic [1:0]                       s_axi_control_rresp,
  input  logic [NUM_CH*DATA_BYTES*8-1:0]   instream_tdata,
  input  logic [NUM_CH-1:0]                instream_tvalid,
  input  logic [NUM_CH-1:0]                instream_tlast,
  output logic [NUM_CH-1:0]                instream_tready,
  output logic [NUM_CH*DATA_BYTES*8-1:0]   outstream_tdata,
  output logic [NUM_CH-1:0]                outstream_tvalid,
  output logic [NUM_CH-1:0]                outstream_tlast,
  input  logic [NUM_CH-1:0]                outstream_tready
);

  localparam int unsigned DW = DATA_BYTES * 8;
`ifdef AXIS_MEASURE_STALL_EN
  localparam logic STALL_PRESENT = 1'b1;
`else
  localparam logic STALL_PRESENT = 1'b0;
`endif
  localparam logic [31:0] STATUS_WORD = {7'b0, STALL_PRESENT, 16'(DATA_BYTES), 8'(NUM_CH)};

  logic                             run_q, run_d;
  logic [CNT_WIDTH-1:0]             cycles_q, cycles_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] beats_q, beats_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] pkts_q, pkts_d;
`ifdef AXIS_MEASURE_STALL_EN
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] stalls_q, stalls_d;
`endif
  logic [NUM_CH-1:0][31:0]          last_q, last_d;
  logic [31:0]                      shadow_q, shadow_d;

  logic        aw_held_q, aw_held_d;
  logic [15:0] awaddr_q, awaddr_d;
  logic        w_held_q, w_held_d;
  logic [1:0]  wbits_q, wbits_d;
  logic        wstrb0_q, wstrb0_d;
  logic        bvalid_q, bvalid_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;

  logic        aw_hs, w_hs, ar_hs, do_write, ctrl_wr, clear;
  logic [31:0] rd_word, rd_hi;
  logic        rd_lo;
  logic [63:0] cyc64;
  logic        unused_wbits;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_WIDTH'(1) : v;
  endfunction

  function automatic logic [63:0] ext64(input logic [CNT_WIDTH-1:0] v);
    logic [63:0] r;
    r = '0;
    r[CNT_WIDTH-1:0] = v;
    return r;
  endfunction

  assign outstream_tdata  = instream_tdata;
  assign outstream_tvalid = instream_tvalid;
  assign outstream_tlast  = instream_tlast;
  assign instream_tready  = outstream_tready;

  assign s_axi_control_awready = ~aw_held_q & ~bvalid_q;
  assign s_axi_control_wready  = ~w_held_q & ~bvalid_q;
  assign s_axi_control_bvalid  = bvalid_q;
  assign s_axi_control_bresp   = 2'b00;
  assign s_axi_control_arready = ~rvalid_q;
  assign s_axi_control_rvalid  = rvalid_q;
  assign s_axi_control_rdata   = rdata_q;
  assign s_axi_control_rresp   = 2'b00;

  assign unused_wbits = ^{s_axi_control_wdata[31:2], s_axi_control_wstrb[3:1]};

  // Write channel: AW and W latch independently; the commit happens once both are held.
  always_comb begin
    aw_hs    = s_axi_control_awvalid & s_axi_control_awready;
    w_hs     = s_axi_control_wvalid & s_axi_control_wready;
    do_write = aw_held_q & w_held_q;

    aw_held_d = do_write ? 1'b0 : (aw_hs ? 1'b1 : aw_held_q);
    w_held_d  = do_write ? 1'b0 : (w_hs ? 1'b1 : w_held_q);
    awaddr_d  = aw_hs ? s_axi_control_awaddr : awaddr_q;
    wbits_d   = w_hs ? s_axi_control_wdata[1:0] : wbits_q;
    wstrb0_d  = w_hs ? s_axi_control_wstrb[0] : wstrb0_q;

    if (do_write)
      bvalid_d = 1'b1;
    else if (bvalid_q && s_axi_control_bready)
      bvalid_d = 1'b0;
    else
      bvalid_d = bvalid_q;

    ctrl_wr = do_write && (awaddr_q == 16'h0000) && wstrb0_q;
    clear   = ctrl_wr & wbits_q[1];
    run_d   = ctrl_wr ? wbits_q[0] : run_q;
  end

  // Clear takes priority over any increment landing on the same edge.
  always_comb begin
    cycles_d = clear ? '0 : sat_inc(cycles_q, run_q);
    beats_d  = beats_q;
    pkts_d   = pkts_q;
`ifdef AXIS_MEASURE_STALL_EN
    stalls_d = stalls_q;
`endif
    last_d   = last_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      logic beat;
      beat = instream_tvalid[c] & outstream_tready[c];
      if (clear) begin
        beats_d[c] = '0;
        pkts_d[c]  = '0;
        last_d[c]  = '0;
`ifdef AXIS_MEASURE_STALL_EN
        stalls_d[c] = '0;
`endif
      end else begin
        beats_d[c] = sat_inc(beats_q[c], run_q & beat);
        pkts_d[c]  = sat_inc(pkts_q[c], run_q & beat & instream_tlast[c]);
`ifdef AXIS_MEASURE_STALL_EN
        stalls_d[c] = sat_inc(stalls_q[c], run_q & instream_tvalid[c] & ~outstream_tready[c]);
`endif
        if (run_q && beat)
          last_d[c] = instream_tdata[c*DW +: 32];
      end
    end
  end

  // Read decode: a lo-word read latches the matching hi word into the shared shadow.
  always_comb begin
    cyc64   = ext64(cycles_q);
    rd_word = 32'hDEAD_BEEF;
    rd_hi   = '0;
    rd_lo   = 1'b0;
    if (s_axi_control_araddr == 16'h0000) begin
      rd_word = {31'b0, run_q};
    end else if (s_axi_control_araddr == 16'h0004) begin
      rd_word = STATUS_WORD;
    end else if (s_axi_control_araddr == 16'h0008) begin
      rd_word = cyc64[31:0];
      rd_hi   = cyc64[63:32];
      rd_lo   = 1'b1;
    end else if (s_axi_control_araddr == 16'h000C) begin
      rd_word = shadow_q;
    end
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (s_axi_control_araddr[15:5] == 11'(c + 2)) begin
        case (s_axi_control_araddr[4:0])
          5'h00: begin
            rd_word = ext64(beats_q[c])[31:0];
            rd_hi   = ext64(beats_q[c])[63:32];
            rd_lo   = 1'b1;
          end
          5'h04: rd_word = shadow_q;
          5'h08: begin
            rd_word = ext64(pkts_q[c])[31:0];
            rd_hi   = ext64(pkts_q[c])[63:32];
            rd_lo   = 1'b1;
          end
          5'h0C: rd_word = shadow_q;
`ifdef AXIS_MEASURE_STALL_EN
          5'h10: begin
            rd_word = ext64(stalls_q[c])[31:0];
            rd_hi   = ext64(stalls_q[c])[63:32];
            rd_lo   = 1'b1;
          end
          5'h14: rd_word = shadow_q;
`else
          5'h10: begin
            rd_word = '0;
            rd_lo   = 1'b1;
          end
          5'h14: rd_word = '0;
`endif
          5'h18: rd_word = last_q[c];
          default: rd_word = 32'hDEAD_BEEF;
        endcase
      end
    end

    ar_hs    = s_axi_control_arvalid & s_axi_control_arready;
    rdata_d  = ar_hs ? rd_word : rdata_q;
    shadow_d = (ar_hs && rd_lo) ? rd_hi : shadow_q;
    if (ar_hs)
      rvalid_d = 1'b1;
    else if (rvalid_q && s_axi_control_rready)
      rvalid_d = 1'b0;
    else
      rvalid_d = rvalid_q;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      run_q     <= START_ENABLED;
      cycles_q  <= '0;
      beats_q   <= '0;
      pkts_q    <= '0;
`ifdef AXIS_MEASURE_STALL_EN
      stalls_q  <= '0;
`endif
      last_q    <= '0;
      shadow_q  <= '0;
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wbits_q   <= '0;
      wstrb0_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      run_q     <= run_d;
      cycles_q  <= cycles_d;
      beats_q   <= beats_d;
      pkts_q    <= pkts_d;
`ifdef AXIS_MEASURE_STALL_EN
      stalls_q  <= stalls_d;
`endif
      last_q    <= last_d;
      shadow_q  <= shadow_d;
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wbits_q   <= wbits_d;
      wstrb0_q  <= wstrb0_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule
